// File: rtl/siphash_pkg.sv
// ----------------------------------------------------------------------------
// siphash_pkg
// Shared definitions for the SipHash message sequencer:
//   - state_t       : controller FSM states
//   - C/D defaults  : default compression / finalization round counts
//   - clamp_nbytes  : limits a byte count to 0..8
//   - tail_pad      : builds the final SipHash block (tail bytes + length byte)
// ----------------------------------------------------------------------------
package siphash_pkg;

    localparam int unsigned C_ROUNDS_DEF = 2;
    localparam int unsigned D_ROUNDS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACCEPT,
        COMP,
        CWAIT,
        PAD,
        FIN,
        FWAIT
    } state_t;

    function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

    // Keeps bytes 0..n-1 of data, zeroes bytes n..6 and puts (len + n) mod 256
    // in byte 7. A full word (n == 8) passes through unchanged.
    function automatic logic [63:0] tail_pad(input logic [63:0] data,
                                             input logic [3:0]  nbytes,
                                             input logic [7:0]  len);
        logic [63:0] blk;
        if (nbytes >= 4'd8) begin
            return data;
        end
        blk = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (i < 32'(nbytes)) begin
                blk[8*i +: 8] = data[8*i +: 8];
            end
        end
        blk[63:56] = len + 8'(nbytes);
        return blk;
    endfunction

endpackage

// File: rtl/siphash_msg_ctrl_if.sv
// ----------------------------------------------------------------------------
// siphash_msg_ctrl_if
// Message word stream into the SipHash sequencer.
//   in_valid  : word valid (source)
//   in_ready  : sequencer accepts the word this cycle (sink)
//   in_data   : 64-bit word, byte i at bits [8i+7:8i]
//   in_last   : final word of the message
//   in_nbytes : valid bytes in the final word, 0..8
// Modports: master = word source, slave = sequencer.
// ----------------------------------------------------------------------------
interface siphash_msg_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_nbytes;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output in_nbytes,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_nbytes,
        output in_ready
    );

endinterface

// File: rtl/siphash_tail_pad.sv
// ----------------------------------------------------------------------------
// siphash_tail_pad
// Combinational final-block builder.
//   data   : raw last message word
//   nbytes : valid bytes in data (values above 8 treated as 8)
//   len    : message length so far, mod 256, excluding this word
//   block  : padded block with the length byte in bits [63:56]
// ----------------------------------------------------------------------------
module siphash_tail_pad
    import siphash_pkg::*;
(
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    input  logic [7:0]  len,
    output logic [63:0] block
);

    assign block = tail_pad(data, clamp_nbytes(nbytes), len);

endmodule

// File: rtl/siphash_msg_ctrl.sv
// ----------------------------------------------------------------------------
// siphash_msg_ctrl
// Message sequencer for siphash_core: latches the key, feeds message words as
// compression blocks, appends the SipHash length/pad block, runs finalization
// and captures the digest.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, key          : begin a new hash (ignored while busy)
//   msg                 : message word stream (slave side)
//   busy                : hash in progress
//   digest/digest_valid : result (held) and one-cycle update pulse
//   core_*              : strobes, key, block and round counts to the core;
//                         core_ready / core_word / core_word_valid back
// ----------------------------------------------------------------------------
module siphash_msg_ctrl
    import siphash_pkg::*;
#(
    parameter int unsigned C_ROUNDS = C_ROUNDS_DEF,
    parameter int unsigned D_ROUNDS = D_ROUNDS_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [127:0]        key,
    siphash_msg_ctrl_if.slave   msg,
    output logic                busy,
    output logic [63:0]         digest,
    output logic                digest_valid,
    output logic                core_initalize,
    output logic                core_compress,
    output logic                core_finalize,
    output logic [127:0]        core_k,
    output logic [63:0]         core_mi,
    output logic [3:0]          core_c,
    output logic [3:0]          core_d,
    input  logic                core_ready,
    input  logic [63:0]         core_word,
    input  logic                core_word_valid
);

    state_t      state_q, state_d;
    logic [7:0]  len_ctr;
    logic        last_seen;
    logic        pad_pend;
    logic        cwait_first;
    logic [3:0]  n_clamp;
    logic [63:0] pad_blk;

    assign core_c  = 4'(C_ROUNDS);
    assign core_d  = 4'(D_ROUNDS);
    assign n_clamp = clamp_nbytes(msg.in_nbytes);

    siphash_tail_pad u_tail_pad (
        .data   (msg.in_data),
        .nbytes (msg.in_nbytes),
        .len    (len_ctr),
        .block  (pad_blk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // busy stays high through the digest_valid cycle, so a start arriving
    // together with the pulse is still rejected in IDLE.
    always_comb begin
        state_d      = state_q;
        msg.in_ready = 1'b0;
        case (state_q)
            IDLE:    if (start && !busy) state_d = INIT;
            INIT:    state_d = ACCEPT;
            ACCEPT: begin
                msg.in_ready = 1'b1;
                if (msg.in_valid) state_d = COMP;
            end
            COMP:    state_d = CWAIT;
            // The core lowers core_ready one cycle after the strobe, so the
            // first CWAIT cycle must not trust it.
            CWAIT: begin
                if (!cwait_first && core_ready) begin
                    if (!last_seen)    state_d = ACCEPT;
                    else if (pad_pend) state_d = PAD;
                    else               state_d = FIN;
                end
            end
            PAD:     state_d = COMP;
            FIN:     state_d = FWAIT;
            FWAIT:   if (core_word_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            digest         <= '0;
            digest_valid   <= 1'b0;
            core_initalize <= 1'b0;
            core_compress  <= 1'b0;
            core_finalize  <= 1'b0;
            core_k         <= '0;
            core_mi        <= '0;
            len_ctr        <= '0;
            last_seen      <= 1'b0;
            pad_pend       <= 1'b0;
            cwait_first    <= 1'b0;
        end else begin
            // Strobes follow the state being entered, giving one-cycle pulses
            // aligned with the state that owns them.
            core_initalize <= (state_d == INIT);
            core_compress  <= (state_d == COMP);
            core_finalize  <= (state_d == FIN);
            cwait_first    <= (state_q == COMP);
            digest_valid   <= 1'b0;
            if (digest_valid) busy <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start && !busy) begin
                        core_k    <= key;
                        len_ctr   <= '0;
                        last_seen <= 1'b0;
                        pad_pend  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ACCEPT: begin
                    if (msg.in_valid) begin
                        if (msg.in_last) begin
                            core_mi   <= pad_blk;
                            len_ctr   <= len_ctr + 8'(n_clamp);
                            last_seen <= 1'b1;
                            pad_pend  <= (n_clamp == 4'd8);
                        end else begin
                            core_mi <= msg.in_data;
                            len_ctr <= len_ctr + 8'd8;
                        end
                    end
                end
                PAD: begin
                    core_mi  <= {len_ctr, 56'h0};
                    pad_pend <= 1'b0;
                end
                FWAIT: begin
                    if (core_word_valid) begin
                        digest       <= core_word;
                        digest_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_siphash_msg_ctrl
// Directed bench for siphash_msg_ctrl paired with a behavioural SipHash core.
// ----------------------------------------------------------------------------
module tb_siphash_msg_ctrl;

    localparam int unsigned C_R = 2;
    localparam int unsigned D_R = 4;
    localparam logic [127:0] KEY_A = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [63:0]  DIG_EMPTY = 64'h726fdb47dd0e0e31;
    localparam logic [63:0]  DIG_15    = 64'ha129ca6149be45e5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic [63:0]  digest;
    logic         digest_valid;
    logic         core_initalize, core_compress, core_finalize;
    logic [127:0] core_k;
    logic [63:0]  core_mi;
    logic [3:0]   core_c, core_d;
    logic         core_ready;
    logic [63:0]  core_word;
    logic         core_word_valid;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [63:0]  mi_log[$];
    int unsigned  base;

    always #5 clk = ~clk;

    siphash_msg_ctrl_if mif ();

    siphash_msg_ctrl #(
        .C_ROUNDS (C_R),
        .D_ROUNDS (D_R)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .key             (key),
        .msg             (mif),
        .busy            (busy),
        .digest          (digest),
        .digest_valid    (digest_valid),
        .core_initalize  (core_initalize),
        .core_compress   (core_compress),
        .core_finalize   (core_finalize),
        .core_k          (core_k),
        .core_mi         (core_mi),
        .core_c          (core_c),
        .core_d          (core_d),
        .core_ready      (core_ready),
        .core_word       (core_word),
        .core_word_valid (core_word_valid)
    );

    // ---------------- behavioural SipHash core ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [255:0] sip_round(input logic [255:0] s);
        logic [63:0] a, b, c, d;
        {d, c, b, a} = s;
        a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
        c = c + d; d = rotl(d, 16); d = d ^ c;
        a = a + d; d = rotl(d, 21); d = d ^ a;
        c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
        return {d, c, b, a};
    endfunction

    function automatic logic [255:0] sip_init(input logic [127:0] k);
        return {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
                k[127:64] ^ 64'h646f72616e646f6d, k[63:0] ^ 64'h736f6d6570736575};
    endfunction

    function automatic logic [255:0] sip_comp(input logic [255:0] s, input logic [63:0] m,
                                              input int unsigned n);
        logic [255:0] t;
        t = s;
        t[255:192] = t[255:192] ^ m;
        for (int unsigned i = 0; i < n; i++) t = sip_round(t);
        t[63:0] = t[63:0] ^ m;
        return t;
    endfunction

    function automatic logic [63:0] sip_fin(input logic [255:0] s, input int unsigned n);
        logic [255:0] t;
        t = s;
        t[191:128] = t[191:128] ^ 64'hff;
        for (int unsigned i = 0; i < n; i++) t = sip_round(t);
        return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
    endfunction

    logic [255:0] vs;
    int unsigned  cnt, fcnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs              <= '0;
            cnt             <= 0;
            fcnt            <= 0;
            core_ready      <= 1'b1;
            core_word       <= '0;
            core_word_valid <= 1'b0;
        end else begin
            core_ready      <= (cnt == 0);
            core_word_valid <= 1'b0;
            if (cnt != 0) cnt <= cnt - 1;
            if (core_initalize) begin
                vs <= sip_init(core_k);
            end else if (core_compress) begin
                vs  <= sip_comp(vs, core_mi, C_R);
                cnt <= C_R + 2;
            end
            if (core_finalize) begin
                core_word <= sip_fin(vs, D_R);
                fcnt      <= D_R + 2;
            end else if (fcnt != 0) begin
                fcnt <= fcnt - 1;
                if (fcnt == 1) core_word_valid <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && core_compress) mi_log.push_back(core_mi);
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] n);
        int unsigned t;
        t = 0;
        mif.in_valid  = 1'b1;
        mif.in_data   = d;
        mif.in_last   = last;
        mif.in_nbytes = n;
        while (!mif.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", 64'(mif.in_ready), 64'd1);
        @(negedge clk);
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_digest(input string tag, input logic has_exp, input logic [63:0] exp);
        int unsigned t;
        t = 0;
        while (!digest_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_dvalid"}, 64'(digest_valid), 64'd1);
        if (has_exp) check({tag, "_digest"}, digest, exp);
        check({tag, "_busy_on_pulse"}, 64'(busy), 64'd1);
        // start coinciding with the pulse must be ignored
        do_start(~KEY_A);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_still_idle"}, 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        key           = '0;
        mif.in_valid  = 1'b0;
        mif.in_data   = '0;
        mif.in_last   = 1'b0;
        mif.in_nbytes = '0;
        #12;
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_dvalid",   64'(digest_valid), 64'd0);
        check("rst_digest",   digest, 64'd0);
        check("rst_in_ready", 64'(mif.in_ready), 64'd0);
        check("rst_strobes",  64'({core_initalize, core_compress, core_finalize}), 64'd0);
        check("rst_core_k",   core_k[63:0] | core_k[127:64], 64'd0);
        check("rst_core_mi",  core_mi, 64'd0);
        check("core_c",       64'(core_c), 64'd2);
        check("core_d",       64'(core_d), 64'd4);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: empty message, junk in_data must be masked away
        base = mi_log.size();
        do_start(KEY_A);
        check("s1_busy", 64'(busy), 64'd1);
        send_word(64'hdeadbeefcafef00d, 1'b1, 4'd0);
        wait_digest("s1", 1'b1, DIG_EMPTY);
        check("s1_ncomp", 64'(mi_log.size() - base), 64'd1);
        check("s1_mi0",   mi_log[base], 64'h0);

        // 2 + 4: 15 bytes, valid held while the controller is busy
        base = mi_log.size();
        do_start(KEY_A);
        send_word(64'h0706050403020100, 1'b0, 4'd8);
        mif.in_valid  = 1'b1;
        mif.in_data   = 64'hff0e0d0c0b0a0908;
        mif.in_last   = 1'b1;
        mif.in_nbytes = 4'd7;
        check("s4_ready_comp", 64'(mif.in_ready), 64'd0);
        @(negedge clk);
        check("s4_ready_cwait", 64'(mif.in_ready), 64'd0);
        @(negedge clk);
        check("s4_ready_cwait2", 64'(mif.in_ready), 64'd0);
        check("s4_ncomp_mid", 64'(mi_log.size() - base), 64'd1);
        send_word(64'hff0e0d0c0b0a0908, 1'b1, 4'd7);
        wait_digest("s2", 1'b1, DIG_15);
        check("s2_ncomp", 64'(mi_log.size() - base), 64'd2);
        check("s2_mi0",   mi_log[base],     64'h0706050403020100);
        check("s2_mi1",   mi_log[base + 1], 64'h0f0e0d0c0b0a0908);

        // 3: exactly 8 bytes -> separate length block
        base = mi_log.size();
        do_start(KEY_A);
        send_word(64'h0706050403020100, 1'b1, 4'd8);
        wait_digest("s3", 1'b0, 64'h0);
        check("s3_ncomp", 64'(mi_log.size() - base), 64'd2);
        check("s3_mi0",   mi_log[base],     64'h0706050403020100);
        check("s3_mi1",   mi_log[base + 1], 64'h0800000000000000);

        // 3b: nbytes above 8 behaves as 8
        base = mi_log.size();
        do_start(KEY_A);
        send_word(64'h1716151413121110, 1'b1, 4'd15);
        wait_digest("s3b", 1'b0, 64'h0);
        check("s3b_ncomp", 64'(mi_log.size() - base), 64'd2);
        check("s3b_mi0",   mi_log[base],     64'h1716151413121110);
        check("s3b_mi1",   mi_log[base + 1], 64'h0800000000000000);

        // 5: 264 bytes, length byte wraps to 8
        base = mi_log.size();
        do_start(KEY_A);
        for (int unsigned w = 0; w < 33; w++) begin
            send_word({32'h5a5a0000 | w, w}, 1'b0, 4'd8);
        end
        send_word(64'h1122334455667788, 1'b1, 4'd0);
        wait_digest("s5", 1'b0, 64'h0);
        check("s5_ncomp", 64'(mi_log.size() - base), 64'd34);
        check("s5_mi32",  mi_log[base + 32], {32'h5a5a0020, 32'd32});
        check("s5_milast", mi_log[base + 33], 64'h0800000000000000);

        // 6: async reset during CWAIT, then a clean rerun of scenario 1
        do_start(KEY_A);
        send_word(64'h0706050403020100, 1'b0, 4'd8);
        @(negedge clk);
        @(negedge clk);
        check("s6_busy_pre", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("s6_busy",     64'(busy), 64'd0);
        check("s6_in_ready", 64'(mif.in_ready), 64'd0);
        check("s6_digest",   digest, 64'd0);
        check("s6_core_mi",  core_mi, 64'd0);
        check("s6_core_k",   core_k[63:0] | core_k[127:64], 64'd0);
        check("s6_strobes",  64'({core_initalize, core_compress, core_finalize, digest_valid}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base = mi_log.size();
        do_start(KEY_A);
        send_word(64'h0, 1'b1, 4'd0);
        wait_digest("s6r", 1'b1, DIG_EMPTY);
        check("s6r_ncomp", 64'(mi_log.size() - base), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
